lsu_rmw: RTL and testbench

Load/store unit sitting directly upstream of the word-wide data memory; consumes core load/store requests and drives the memory's Address/Write_data/Mem_write/Mem_read.
Converts byte addresses to word indices and performs byte/halfword extraction with sign/zero extension.
Implements sub-word stores as a read-modify-write sequence.
Flags misaligned, out-of-range and reserved-encoding accesses without touching memory.

---
 rtl/lsu_rmw_pkg.sv | 20 ++
 rtl/lsu_rmw_lane.sv | 50 +++++
 rtl/lsu_rmw.sv | 155 +++++++++++++++
 tb/tb_lsu_rmw.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_rmw_pkg.sv
// lsu_rmw shared definitions
// funct3 encodings, FSM states, default memory depth
package lsu_rmw_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEPTH_WORDS_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_t;

endpackage

// File: rtl/lsu_rmw_lane.sv
// lsu_rmw byte/half lane logic
// load extraction with extension, store merge into a word
module lsu_rmw_lane
  import lsu_rmw_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  input  logic [31:0] sdata,
  output logic [31:0] ldata,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [4:0]  bsh;
  logic [4:0]  hsh;

  // pick the addressed byte/half and extend per funct3
  always_comb begin
    bsh   = {off, 3'b000};
    hsh   = {off[1], 4'b0000};
    b     = 8'(word >> bsh);
    h     = off[1] ? word[31:16] : word[15:0];
    ldata = word;
    unique case (1'b1)
      (f3 == F3_B):  ldata = {{24{b[7]}}, b};
      (f3 == F3_BU): ldata = {24'h0, b};
      (f3 == F3_H):  ldata = {{16{h[15]}}, h};
      (f3 == F3_HU): ldata = {16'h0, h};
      default:       ldata = word;
    endcase
  end

  // splice the store byte/half into its lane of the old word
  always_comb begin
    merged = sdata;
    unique case (1'b1)
      (f3 == F3_B):
        merged = (word & ~(32'h0000_00ff << bsh))
               | ({24'h0, sdata[7:0]} << bsh);
      (f3 == F3_H):
        merged = (word & ~(32'h0000_ffff << hsh))
               | ({16'h0, sdata[15:0]} << hsh);
      default:
        merged = sdata;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw load/store unit
// word memory front end with read-modify-write sub-word stores
module lsu_rmw
  import lsu_rmw_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);

  state_t            state;
  state_t            state_nx;
  logic              st_store;
  logic [2:0]        st_f3;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_wdata;
  logic [31:0]       merged_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              accept;
  logic              is_h;
  logic              mis;
  logic              oor;
  logic              rsv;
  logic              req_bad;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       lane_ldata;
  logic [31:0]       lane_merged;

  assign accept     = req_valid && req_ready;
  assign word_idx   = {2'b00, st_addr[ADDR_W-1:2]};
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  lsu_rmw_lane u_lane (
    .word   (mem_rdata),
    .off    (st_addr[1:0]),
    .f3     (st_f3),
    .sdata  (st_wdata),
    .ldata  (lane_ldata),
    .merged (lane_merged)
  );

  // classify the incoming request; any hit skips memory
  always_comb begin
    is_h = (req_funct3 == F3_H)
        || (!req_store && req_funct3 == F3_HU);
    mis  = (is_h && req_addr[0])
        || (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
    oor  = {1'b0, req_addr} >= LIMIT;
    rsv  = req_store
         ? (req_funct3 >= 3'b011)
         : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    req_bad = mis || oor || rsv;
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state and memory strobes, all decoded from current state
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = 32'h0;
    mem_addr   = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_addr = word_idx;
        if (!st_store) begin
          mem_read = 1'b1;
          state_nx = RESP;
        end else if (st_f3 == F3_W) begin
          mem_write = 1'b1;
          mem_wdata = st_wdata;
          state_nx  = RESP;
        end else begin
          mem_read = 1'b1;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        mem_addr  = word_idx;
        mem_write = 1'b1;
        mem_wdata = merged_q;
        state_nx  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // capture request, merged word and response payload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_store <= 1'b0;
      st_f3    <= 3'b000;
      st_addr  <= '0;
      st_wdata <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            st_store <= req_store;
            st_f3    <= req_funct3;
            st_addr  <= req_addr;
            st_wdata <= req_wdata;
            rdata_q  <= 32'h0;
            err_q    <= req_bad;
          end
        end
        ACCESS: begin
          if (!st_store) rdata_q <= lane_ldata;
          else if (st_f3 != F3_W) merged_q <= lane_merged;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// lsu_rmw bench
// vector table against a word memory model plus stall/reset sequences
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_rmw #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem_read ? mem[mem_addr[5:0]] : 32'h0;

  always @(posedge clk)
    if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        rd;
    logic        wr;
    logic [31:0] mw;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(
    input logic st, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wd,
    input logic [31:0] rdata, input logic err,
    input int lat, input logic rd, input logic wr,
    input logic [31:0] mw);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.rdata = rdata; v.err = err; v.lat = lat;
    v.rd = rd; v.wr = wr; v.mw = mw;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int          lat;
    logic        rd;
    logic        wr;
    logic        both;
    logic [31:0] mw;
    logic [31:0] ma;
    chk($sformatf("v%0d ready", i), {31'h0, req_ready}, 32'h1);
    drive_req(v.st, v.f3, v.addr, v.wd);
    lat = 1; rd = 0; wr = 0; both = 0; mw = 0; ma = 0;
    while (!resp_valid && lat < 10) begin
      if (mem_read) begin rd = 1; ma = mem_addr; end
      if (mem_write) begin wr = 1; mw = mem_wdata; ma = mem_addr; end
      if (mem_read && mem_write) both = 1;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d latency", i), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d rdata", i), resp_rdata, v.rdata);
    chk($sformatf("v%0d err", i), {31'h0, resp_err}, {31'h0, v.err});
    chk($sformatf("v%0d memrd", i), {31'h0, rd}, {31'h0, v.rd});
    chk($sformatf("v%0d memwr", i), {31'h0, wr}, {31'h0, v.wr});
    chk($sformatf("v%0d excl", i), {31'h0, both}, 32'h0);
    if (v.wr) chk($sformatf("v%0d mwdata", i), mw, v.mw);
    if (v.rd || v.wr)
      chk($sformatf("v%0d maddr", i), ma, {2'b00, v.addr[31:2]});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int k = 0; k < 64; k++) mem[k] = 32'(2 * k);

    vecs[0]  = mk(0, 3'b010, 32'h14, 32'h0, 32'h0000000A, 0, 2, 1, 0, 0);
    vecs[1]  = mk(1, 3'b000, 32'h15, 32'h123456FF, 0, 0, 3, 1, 1, 32'h0000FF0A);
    vecs[2]  = mk(0, 3'b000, 32'h15, 0, 32'hFFFFFFFF, 0, 2, 1, 0, 0);
    vecs[3]  = mk(0, 3'b100, 32'h15, 0, 32'h000000FF, 0, 2, 1, 0, 0);
    vecs[4]  = mk(0, 3'b010, 32'h14, 0, 32'h0000FF0A, 0, 2, 1, 0, 0);
    vecs[5]  = mk(1, 3'b001, 32'h1A, 32'h8001, 0, 0, 3, 1, 1, 32'h8001000C);
    vecs[6]  = mk(0, 3'b001, 32'h1A, 0, 32'hFFFF8001, 0, 2, 1, 0, 0);
    vecs[7]  = mk(0, 3'b101, 32'h1A, 0, 32'h00008001, 0, 2, 1, 0, 0);
    vecs[8]  = mk(0, 3'b001, 32'h13, 0, 0, 1, 1, 0, 0, 0);
    vecs[9]  = mk(1, 3'b010, 32'h102, 32'h55, 0, 1, 1, 0, 0, 0);
    vecs[10] = mk(1, 3'b010, 32'h0, 32'hDEADBEEF, 0, 0, 2, 0, 1, 32'hDEADBEEF);
    vecs[11] = mk(0, 3'b010, 32'h0, 0, 32'hDEADBEEF, 0, 2, 1, 0, 0);
    vecs[12] = mk(0, 3'b000, 32'h3, 0, 32'hFFFFFFDE, 0, 2, 1, 0, 0);
    vecs[13] = mk(0, 3'b101, 32'h2, 0, 32'h0000DEAD, 0, 2, 1, 0, 0);
    vecs[14] = mk(0, 3'b010, 32'hFC, 0, 32'h0000007E, 0, 2, 1, 0, 0);
    vecs[15] = mk(0, 3'b010, 32'h100, 0, 0, 1, 1, 0, 0, 0);
    vecs[16] = mk(0, 3'b011, 32'h0, 0, 0, 1, 1, 0, 0, 0);
    vecs[17] = mk(1, 3'b011, 32'h0, 0, 0, 1, 1, 0, 0, 0);
    vecs[18] = mk(0, 3'b110, 32'h0, 0, 0, 1, 1, 0, 0, 0);
    vecs[19] = mk(1, 3'b000, 32'h3, 32'h11, 0, 0, 3, 1, 1, 32'h11ADBEEF);
    vecs[20] = mk(0, 3'b010, 32'h0, 0, 32'h11ADBEEF, 0, 2, 1, 0, 0);
    vecs[21] = mk(1, 3'b101, 32'h0, 32'h77, 0, 1, 1, 0, 0, 0);
    vecs[22] = mk(1, 3'b001, 32'h1, 32'h77, 0, 1, 1, 0, 0, 0);

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    #1;
    chk("rst req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 23; i++) begin
      run_vec(i, vecs[i]);
      if (i == 9) chk("err mem4 kept", mem[4], 32'h00000008);
    end
    chk("mem5", mem[5], 32'h0000FF0A);
    chk("mem6", mem[6], 32'h8001000C);
    chk("mem0", mem[0], 32'h11ADBEEF);

    // response held under back-pressure
    resp_ready = 1'b0;
    drive_req(1'b0, 3'b010, 32'h20, 32'h0);
    n = 1;
    while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("stall latency", 32'(n), 32'd2);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d valid", c), {31'h0, resp_valid}, 32'h1);
      chk($sformatf("stall%0d rdata", c), resp_rdata, 32'h00000010);
      chk($sformatf("stall%0d ready", c), {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    chk("stall release valid", {31'h0, resp_valid}, 32'h1);
    @(posedge clk); #1;
    chk("stall idle ready", {31'h0, req_ready}, 32'h1);
    chk("stall idle valid", {31'h0, resp_valid}, 32'h0);

    // reset during the RMW write phase
    drive_req(1'b1, 3'b000, 32'h08, 32'hAA);
    chk("abort access rd", {31'h0, mem_read}, 32'h1);
    @(posedge clk); #1;
    chk("abort write we", {31'h0, mem_write}, 32'h1);
    chk("abort write data", mem_wdata, 32'h000000AA);
    reset = 1'b1;
    #1;
    chk("abort we drop", {31'h0, mem_write}, 32'h0);
    chk("abort rd drop", {31'h0, mem_read}, 32'h0);
    chk("abort req_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (resp_valid) n++;
    end
    chk("abort no resp", 32'(n), 32'd0);
    chk("abort mem2", mem[2], 32'h00000004);
    chk("abort ready after", {31'h0, req_ready}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
